// File: rtl/dma_pkg.sv
// Shared DMA definitions: arbiter state
// encoding and default ack timeout.
package dma_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_ABORT = 2'd2;

    localparam int TMO_DEF = 255;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority encoder: first request
// at or after ptr+1, wrapping at N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  oh,
    output logic [IW-1:0] idx
);

    logic          found;
    logic [IW-1:0] j;

    // Scan from the slot after the last owner.
    always_comb begin
        oh    = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int i = 1; i <= N; i++) begin
            j = IW'((int'(ptr) + i) % N);
            if (!found && req[j]) begin
                found = 1'b1;
                oh[j] = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/wbm_arb.sv
// Round-robin Wishbone master arbiter with
// ack timeout abort for the DMA engine.
module wbm_arb
    import dma_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TMO  = TMO_DEF
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic [NREQ-1:0]      m_cyc_i,
    input  logic [NREQ-1:0]      m_stb_i,
    input  logic [NREQ-1:0]      m_we_i,
    input  logic [NREQ-1:0]      m_cab_i,
    input  logic [4*NREQ-1:0]    m_sel_i,
    input  logic [32*NREQ-1:0]   m_adr_i,
    input  logic [32*NREQ-1:0]   m_dat_i,
    input  logic [32*NREQ-1:0]   m_dat64_i,
    output logic [31:0]          m_dat_o,
    output logic [31:0]          m_dat64_o,
    output logic [NREQ-1:0]      m_ack_o,
    output logic [NREQ-1:0]      m_err_o,
    output logic [NREQ-1:0]      m_rty_o,
    output logic                 wbs_cyc_o,
    output logic                 wbs_stb_o,
    output logic                 wbs_we_o,
    output logic                 wbs_cab_o,
    output logic [3:0]           wbs_sel_o,
    output logic [31:0]          wbs_adr_o,
    output logic [31:0]          wbs_dat_o,
    output logic [31:0]          wbs_dat64_o,
    input  logic [31:0]          wbs_dat_i,
    input  logic [31:0]          wbs_dat64_i,
    input  logic                 wbs_ack_i,
    input  logic                 wbs_err_i,
    input  logic                 wbs_rty_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic                 tmo_o,
    output logic [1:0]           arb_state
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [1:0]      state;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   ptr;
    logic [7:0]      timer;
    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            own_cyc;
    logic            own_stb;
    logic            granted;
    logic            term;
    logic            hit;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req (m_cyc_i),
        .ptr (ptr),
        .oh  (pick_oh),
        .idx (pick_idx)
    );

    // Forward the owner's cycle; no owner reads as all zero.
    always_comb begin
        own_cyc     = 1'b0;
        own_stb     = 1'b0;
        wbs_we_o    = 1'b0;
        wbs_cab_o   = 1'b0;
        wbs_sel_o   = '0;
        wbs_adr_o   = '0;
        wbs_dat_o   = '0;
        wbs_dat64_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                own_cyc     = m_cyc_i[k];
                own_stb     = m_stb_i[k];
                wbs_we_o    = m_we_i[k];
                wbs_cab_o   = m_cab_i[k];
                wbs_sel_o   = m_sel_i[4*k +: 4];
                wbs_adr_o   = m_adr_i[32*k +: 32];
                wbs_dat_o   = m_dat_i[32*k +: 32];
                wbs_dat64_o = m_dat64_i[32*k +: 32];
            end
        end
    end

    assign granted = (state == S_GRANT);
    assign term    = wbs_ack_i | wbs_err_i | wbs_rty_i;
    // Abort on the TMO-th consecutive unterminated strobe.
    assign hit     = granted & own_stb & ~term
                   & (timer == 8'(TMO - 1));

    assign wbs_cyc_o = granted & own_cyc;
    assign wbs_stb_o = granted & own_stb;

    assign m_ack_o = gnt & {NREQ{granted & wbs_ack_i}};
    assign m_err_o = gnt & {NREQ{granted & (wbs_err_i | hit)}};
    assign m_rty_o = gnt & {NREQ{granted & wbs_rty_i}};

    assign m_dat_o   = wbs_dat_i;
    assign m_dat64_o = wbs_dat64_i;
    assign gnt_o     = gnt;
    assign tmo_o     = hit;
    assign arb_state = state;

    // Tenure FSM: grant, release/timeout, abort drain.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= S_IDLE;
            gnt   <= '0;
            ptr   <= IW'(NREQ - 1);
            timer <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|m_cyc_i) begin
                        gnt   <= pick_oh;
                        ptr   <= pick_idx;
                        timer <= '0;
                        state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (hit) begin
                        timer <= '0;
                        state <= S_ABORT;
                    end else if (!own_cyc) begin
                        gnt   <= '0;
                        timer <= '0;
                        state <= S_IDLE;
                    end else if (own_stb && !term) begin
                        timer <= timer + 8'd1;
                    end else begin
                        timer <= '0;
                    end
                end
                S_ABORT: begin
                    if (!own_cyc) begin
                        gnt   <= '0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    gnt   <= '0;
                    timer <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wbm_arb.sv
// Testbench for wbm_arb: directed scenarios plus
// random traffic against a behavioural model.
module tb_wbm_arb;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n;

    logic [N-1:0]    cyc, stb, we, cab;
    logic [4*N-1:0]  sel;
    logic [32*N-1:0] adr, dat, dat64;
    logic [31:0]     s_dat, s_dat64;
    logic            s_ack, s_err, s_rty;

    logic [31:0]  m_dat_o, m_dat64_o;
    logic [N-1:0] m_ack_o, m_err_o, m_rty_o;
    logic         wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_cab_o;
    logic [3:0]   wbs_sel_o;
    logic [31:0]  wbs_adr_o, wbs_dat_o, wbs_dat64_o;
    logic [N-1:0] gnt_o;
    logic         tmo_o;
    logic [1:0]   arb_state;

    wbm_arb #(.NREQ(N), .TMO(TMO)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .m_cyc_i     (cyc),
        .m_stb_i     (stb),
        .m_we_i      (we),
        .m_cab_i     (cab),
        .m_sel_i     (sel),
        .m_adr_i     (adr),
        .m_dat_i     (dat),
        .m_dat64_i   (dat64),
        .m_dat_o     (m_dat_o),
        .m_dat64_o   (m_dat64_o),
        .m_ack_o     (m_ack_o),
        .m_err_o     (m_err_o),
        .m_rty_o     (m_rty_o),
        .wbs_cyc_o   (wbs_cyc_o),
        .wbs_stb_o   (wbs_stb_o),
        .wbs_we_o    (wbs_we_o),
        .wbs_cab_o   (wbs_cab_o),
        .wbs_sel_o   (wbs_sel_o),
        .wbs_adr_o   (wbs_adr_o),
        .wbs_dat_o   (wbs_dat_o),
        .wbs_dat64_o (wbs_dat64_o),
        .wbs_dat_i   (s_dat),
        .wbs_dat64_i (s_dat64),
        .wbs_ack_i   (s_ack),
        .wbs_err_i   (s_err),
        .wbs_rty_i   (s_rty),
        .gnt_o       (gnt_o),
        .tmo_o       (tmo_o),
        .arb_state   (arb_state)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: who owns the bus, whether the
    // tenure was aborted, who owned last, and how many
    // consecutive unterminated strobes have been seen.
    int owner;
    int last;
    int tcount;
    bit aborted;

    logic [N-1:0] eack, eerr, erty;
    logic [N-1:0] o_ack;
    logic         o_tmo;
    int           beats [N];

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner   = -1;
        last    = N - 1;
        tcount  = 0;
        aborted = 1'b0;
    endtask

    task automatic clear_inputs();
        cyc = '0; stb = '0; we = '0; cab = '0;
        sel = '0; adr = '0; dat = '0; dat64 = '0;
        s_dat = '0; s_dat64 = '0;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    endtask

    // One clock: check outputs mid-cycle, advance model,
    // return at posedge+1 ready for new stimulus.
    task automatic cycle();
        logic         granted, term, tmo;
        logic [N-1:0] eg, one;
        logic [1:0]   est;
        @(negedge clk);
        one     = 1;
        granted = (owner >= 0) && !aborted;
        term    = s_ack | s_err | s_rty;
        tmo     = granted && stb[owner] && !term
                  && (tcount + 1 == TMO);
        eg      = (owner >= 0) ? (one << owner) : '0;
        est     = (owner < 0) ? 2'd0 : (aborted ? 2'd2 : 2'd1);
        eack    = (granted && s_ack) ? eg : '0;
        eerr    = (granted && (s_err || tmo)) ? eg : '0;
        erty    = (granted && s_rty) ? eg : '0;
        o_ack   = m_ack_o;
        o_tmo   = tmo_o;
        chk("gnt", gnt_o, eg);
        chk("state", arb_state, est);
        chk("cyc", wbs_cyc_o, granted ? cyc[owner] : 1'b0);
        chk("stb", wbs_stb_o, granted ? stb[owner] : 1'b0);
        chk("ack", m_ack_o, eack);
        chk("err", m_err_o, eerr);
        chk("rty", m_rty_o, erty);
        chk("tmo", tmo_o, tmo);
        chk("rdat", {m_dat_o, m_dat64_o}, {s_dat, s_dat64});
        if (owner < 0)
            chk("bus0", {wbs_we_o, wbs_cab_o, wbs_sel_o,
                         wbs_adr_o, wbs_dat_o, wbs_dat64_o}, '0);
        else if (!aborted)
            chk("bus", {wbs_we_o, wbs_cab_o, wbs_sel_o,
                        wbs_adr_o, wbs_dat_o, wbs_dat64_o},
                {we[owner], cab[owner], sel[4*owner +: 4],
                 adr[32*owner +: 32], dat[32*owner +: 32],
                 dat64[32*owner +: 32]});
        if (!rst_n) begin
            model_reset();
        end else if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (last + k) % N;
                if (owner < 0 && cyc[j]) begin
                    owner  = j;
                    last   = j;
                    tcount = 0;
                end
            end
        end else if (!aborted) begin
            if (tmo) begin
                aborted = 1'b1;
                tcount  = 0;
            end else if (!cyc[owner]) begin
                owner = -1;
            end else if (stb[owner] && !term) begin
                tcount++;
            end else begin
                tcount = 0;
            end
        end else if (!cyc[owner]) begin
            owner   = -1;
            aborted = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset taken between clock edges.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_cyc", wbs_cyc_o, 1'b0);
        chk("rst_gnt", gnt_o, '0);
        model_reset();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int acks;
        int tmo_at;
        int tmo_hits;
        int order [$];
        logic [N-1:0] prev_g;
        bit hang;
        int r;

        clear_inputs();
        for (int k = 0; k < N; k++) beats[k] = 0;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        cycle();
        cycle();
        rst_n = 1'b1;

        // Requester 1: 4-beat burst read, ack every beat.
        cyc[1] = 1'b1; stb[1] = 1'b1; cab[1] = 1'b1;
        adr[32 +: 32] = 32'h1000_0040; sel[4 +: 4] = 4'hF;
        cycle();
        chk("t1_gnt", gnt_o, 4'b0010);
        acks = 0;
        s_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (o_ack == 4'b0010) acks++;
        end
        cyc = '0; stb = '0; cab = '0; s_ack = 1'b0;
        cycle();
        cycle();
        chk("t1_acks", acks, 4);
        chk("t1_rel", gnt_o, '0);

        // All four request at once, one beat each.
        do_reset();
        cyc = 4'hF; stb = 4'hF; s_ack = 1'b1;
        prev_g = '0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            for (int k = 0; k < N; k++)
                if (eack[k]) begin
                    cyc[k] = 1'b0;
                    stb[k] = 1'b0;
                end
            if (gnt_o != '0 && gnt_o != prev_g)
                for (int k = 0; k < N; k++)
                    if (gnt_o[k]) order.push_back(k);
            prev_g = gnt_o;
        end
        s_ack = 1'b0;
        chk("rr_len", order.size(), 4);
        for (int k = 0; k < 4; k++)
            chk("rr_order", (k < order.size()) ? order[k] : -1, k);

        // Hung slave: abort on the 16th unterminated strobe.
        do_reset();
        cyc[3] = 1'b1; stb[3] = 1'b1;
        tmo_at = -1;
        for (int i = 0; i < 22; i++) begin
            cycle();
            if (o_tmo) tmo_at = i;
        end
        chk("tmo_at", tmo_at, 16);
        chk("abort_st", arb_state, 2'd2);
        cyc = '0; stb = '0;
        cycle();
        cycle();
        chk("abort_idle", arb_state, 2'd0);

        // Ack lands exactly on the timeout cycle.
        cyc[2] = 1'b1; stb[2] = 1'b1;
        tmo_hits = 0;
        acks = 0;
        for (int i = 0; i < 18; i++) begin
            s_ack = (i == 16);
            cycle();
            if (o_tmo) tmo_hits++;
            if (o_ack == 4'b0100) acks++;
        end
        s_ack = 1'b0;
        chk("late_tmo", tmo_hits, 0);
        chk("late_ack", acks, 1);
        cyc = '0; stb = '0;
        cycle();
        cycle();

        // Reset in the middle of a tenure.
        cyc[1] = 1'b1; stb[1] = 1'b1;
        cycle();
        cycle();
        cyc[0] = 1'b1; stb[0] = 1'b1;
        cycle();
        do_reset();
        cycle();
        chk("post_rst", gnt_o, 4'b0001);
        cyc = '0; stb = '0;
        cycle();
        cycle();

        // Random traffic against the model.
        hang = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) hang = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < N; k++) begin
                if (!cyc[k] && $urandom_range(0, 5) == 0) begin
                    cyc[k]   = 1'b1;
                    beats[k] = $urandom_range(1, 4);
                    cab[k]   = beats[k] > 1;
                end
                stb[k] = cyc[k] && ($urandom_range(0, 11) != 0);
            end
            we    = 4'($urandom());
            sel   = 16'($urandom());
            adr   = {$urandom(), $urandom(), $urandom(), $urandom()};
            dat   = {$urandom(), $urandom(), $urandom(), $urandom()};
            dat64 = {$urandom(), $urandom(), $urandom(), $urandom()};
            s_dat   = $urandom();
            s_dat64 = $urandom();
            r = $urandom_range(0, 15);
            s_ack = !hang && (r < 2);
            s_err = !hang && (r == 2);
            s_rty = !hang && (r == 3);
            cycle();
            for (int k = 0; k < N; k++) begin
                if (eack[k]) beats[k]--;
                if (eerr[k]) beats[k] = 0;
                if (cyc[k] && beats[k] <= 0) begin
                    cyc[k] = 1'b0;
                    stb[k] = 1'b0;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
